fsm_accum: RTL and testbench

Parametrised sequential adder/accumulator with a three-state control FSM and valid/ready handshakes on both sides. Each accepted input beat presents an operand pair (a, b). The registered pair sum is exposed on every beat. Sums are accumulated over a transaction of up to NUM_OPS beats, and the result is held until the downstream side accepts it. Sits between an operand producer and a result consumer in the datapath test fabric.

---
 rtl/fsm_pkg.sv | 7 +
 rtl/sat_add.sv | 15 +
 rtl/fsm_accum.sv | 71 +++++++
 tb/tb_fsm_accum.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared FSM state encoding and the default accumulator width helper
package fsm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, READY = 2'd2} state_t;
    function automatic int default_acc_w(input int w, input int n);
        return w + 1 + $clog2(n);
    endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: W-bit unsigned adder, wraps (SAT=0) or clamps to all-ones (SAT=1); x,y in, r sum out, ovf carry-out
module sat_add #(
    parameter int W = 4,
    parameter bit SAT = 1'b0
)(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r,
    output logic         ovf
);
    logic [W:0] full;
    assign full = {1'b0, x} + {1'b0, y};
    assign ovf  = full[W];
    assign r    = (SAT && ovf) ? '1 : full[W-1:0];
endmodule

// File: rtl/fsm_accum.sv
// fsm_accum: valid/ready accumulator of (a+b) pair sums over up to NUM_OPS beats
//   in:  clk, rst (async, active-high), in_valid, a, b, in_last, out_ready
//   out: in_ready, sum (a+b of last accepted beat), out_valid, acc, acc_ovf (sticky), state_o
module fsm_accum
    import fsm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 4,
    parameter int ACC_W   = default_acc_w(WIDTH, NUM_OPS),
    parameter bit SAT     = 1'b0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic [WIDTH:0]   sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf,
    output logic [1:0]       state_o
);
    localparam int PW = ACC_W > WIDTH + 1 ? ACC_W : WIDTH + 1;
    localparam int CW = $clog2(NUM_OPS + 1);
    state_t state, state_n;
    logic [CW-1:0] count, cnt_n;
    logic [PW-1:0] pair;
    logic [ACC_W-1:0] acc_base, add_r, acc_n;
    logic add_ovf, pair_hi, ovf_n, take, done;
    assign pair      = PW'(a) + PW'(b);
    // pair bits above ACC_W only exist when ACC_W is narrower than the pair sum
    assign pair_hi   = (pair >> ACC_W) != '0;
    assign acc_base  = state == IDLE ? '0 : acc;
    sat_add #(.W(ACC_W), .SAT(SAT)) u_add (
        .x(acc_base), .y(pair[ACC_W-1:0]), .r(add_r), .ovf(add_ovf)
    );
    assign acc_n     = (SAT && pair_hi) ? '1 : add_r;
    assign ovf_n     = (state == ACCUM && acc_ovf) | add_ovf | pair_hi;
    assign cnt_n     = (state == IDLE ? '0 : count) + CW'(1);
    assign done      = in_last || cnt_n == CW'(NUM_OPS);
    assign in_ready  = state == IDLE || state == ACCUM;
    assign out_valid = state == READY;
    assign state_o   = state;
    assign take      = in_valid && in_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // unused encoding falls back to IDLE
    always_comb begin
        state_n = IDLE;
        state_n = state == READY ? (out_ready ? IDLE : READY) :
                  in_ready ? (take ? (done ? READY : ACCUM) : state) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            count   <= '0;
        end else if (take) begin
            sum     <= pair[WIDTH:0];
            acc     <= acc_n;
            acc_ovf <= ovf_n;
            count   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_fsm_accum.sv
// tb_fsm_accum: directed self-checking bench for fsm_accum (default, ACC_W=5 saturating, ACC_W=5 wrapping)
module tb_fsm_accum;
    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic ir_d, ov_d, of_d, ir_s, ov_s, of_s, ir_w, ov_w, of_w;
    logic [4:0] sum_d, sum_s, sum_w;
    logic [6:0] acc_d;
    logic [4:0] acc_s, acc_w;
    logic [1:0] st_d, st_s, st_w;
    int tests = 0, failures = 0;

    always #5 clk = ~clk;

    fsm_accum dut_d (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d), .a(a), .b(b),
        .in_last(in_last), .sum(sum_d), .out_valid(ov_d), .out_ready(out_ready), .acc(acc_d),
        .acc_ovf(of_d), .state_o(st_d));
    fsm_accum #(.ACC_W(5), .SAT(1'b1)) dut_s (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s),
        .a(a), .b(b), .in_last(in_last), .sum(sum_s), .out_valid(ov_s), .out_ready(out_ready),
        .acc(acc_s), .acc_ovf(of_s), .state_o(st_s));
    fsm_accum #(.ACC_W(5), .SAT(1'b0)) dut_w (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w),
        .a(a), .b(b), .in_last(in_last), .sum(sum_w), .out_valid(ov_w), .out_ready(out_ready),
        .acc(acc_w), .acc_ovf(of_w), .state_o(st_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        tests++; if (st_d !== 2'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", st_d); end
        tests++; if (ov_d !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", ov_d); end
        tests++; if (acc_d !== 7'd0) begin failures++; $display("FAIL reset_acc got %0d exp 0", acc_d); end
        tests++; if (sum_d !== 5'd0) begin failures++; $display("FAIL reset_sum got %0d exp 0", sum_d); end
        tick();
        rst = 1'b0;
        #1;
        tests++; if (ir_d !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", ir_d); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; a = 4'd15; b = 4'd15; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (sum_d !== 5'd30) begin failures++; $display("FAIL single_sum got %0d exp 30", sum_d); end
        tests++; if (acc_d !== 7'd30) begin failures++; $display("FAIL single_acc got %0d exp 30", acc_d); end
        tests++; if (of_d !== 1'b0) begin failures++; $display("FAIL single_ovf got %b exp 0", of_d); end
        tests++; if (ov_d !== 1'b1) begin failures++; $display("FAIL single_out_valid got %b exp 1", ov_d); end
        tests++; if (ir_d !== 1'b0) begin failures++; $display("FAIL single_in_ready got %b exp 0", ir_d); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (st_d !== 2'd0) begin failures++; $display("FAIL single_idle got %0d exp 0", st_d); end
        tests++; if (ir_d !== 1'b1) begin failures++; $display("FAIL single_ready_back got %b exp 1", ir_d); end
    endtask

    task automatic test_auto_terminate();
        logic [3:0] va [4] = '{4'd1, 4'd3, 4'd5, 4'd7};
        logic [3:0] vb [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
        logic [4:0] es [4] = '{5'd3, 5'd7, 5'd11, 5'd15};
        logic [1:0] est [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i];
            tick();
            tests++; if (sum_d !== es[i]) begin failures++; $display("FAIL auto_sum%0d got %0d exp %0d", i, sum_d, es[i]); end
            tests++; if (st_d !== est[i]) begin failures++; $display("FAIL auto_state%0d got %0d exp %0d", i, st_d, est[i]); end
        end
        in_valid = 1'b0;
        tests++; if (acc_d !== 7'd36) begin failures++; $display("FAIL auto_acc got %0d exp 36", acc_d); end
        tests++; if (ir_d !== 1'b0) begin failures++; $display("FAIL auto_in_ready got %b exp 0", ir_d); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; a = 4'd9; b = 4'd9; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (ov_d !== 1'b1) begin failures++; $display("FAIL bp_out_valid%0d got %b exp 1", i, ov_d); end
            tests++; if (acc_d !== 7'd36) begin failures++; $display("FAIL bp_acc%0d got %0d exp 36", i, acc_d); end
            tests++; if (sum_d !== 5'd15) begin failures++; $display("FAIL bp_sum%0d got %0d exp 15", i, sum_d); end
        end
        drain();
        tests++; if (st_d !== 2'd0) begin failures++; $display("FAIL bp_release got %0d exp 0", st_d); end
    endtask

    task automatic test_overflow();
        in_valid = 1'b1; a = 4'd15; b = 4'd15; in_last = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (acc_s !== 5'd31) begin failures++; $display("FAIL ovf_sat_acc got %0d exp 31", acc_s); end
        tests++; if (of_s !== 1'b1) begin failures++; $display("FAIL ovf_sat_flag got %b exp 1", of_s); end
        tests++; if (acc_w !== 5'd28) begin failures++; $display("FAIL ovf_wrap_acc got %0d exp 28", acc_w); end
        tests++; if (of_w !== 1'b1) begin failures++; $display("FAIL ovf_wrap_flag got %b exp 1", of_w); end
        tests++; if (acc_d !== 7'd60) begin failures++; $display("FAIL ovf_wide_acc got %0d exp 60", acc_d); end
        tests++; if (of_d !== 1'b0) begin failures++; $display("FAIL ovf_wide_flag got %b exp 0", of_d); end
        tests++; if (st_s !== 2'd2) begin failures++; $display("FAIL ovf_sat_state got %0d exp 2", st_s); end
        drain();
        in_valid = 1'b1; a = 4'd1; b = 4'd1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (of_s !== 1'b0) begin failures++; $display("FAIL ovf_sat_clear got %b exp 0", of_s); end
        tests++; if (of_w !== 1'b0) begin failures++; $display("FAIL ovf_wrap_clear got %b exp 0", of_w); end
        tests++; if (acc_w !== 5'd2) begin failures++; $display("FAIL ovf_next_acc got %0d exp 2", acc_w); end
        drain();
    endtask

    task automatic test_zero();
        in_valid = 1'b1; a = 4'd0; b = 4'd0; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (ov_d !== 1'b1) begin failures++; $display("FAIL zero_out_valid got %b exp 1", ov_d); end
        tests++; if (acc_d !== 7'd0) begin failures++; $display("FAIL zero_acc got %0d exp 0", acc_d); end
        drain();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a = 4'd1; b = 4'd1; in_last = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        tests++; if (st_d !== 2'd1) begin failures++; $display("FAIL mid_accum got %0d exp 1", st_d); end
        #2 rst = 1'b1;
        #1;
        tests++; if (st_d !== 2'd0) begin failures++; $display("FAIL mid_state got %0d exp 0", st_d); end
        tests++; if (acc_d !== 7'd0) begin failures++; $display("FAIL mid_acc got %0d exp 0", acc_d); end
        #1 rst = 1'b0;
        in_valid = 1'b1; a = 4'd2; b = 4'd3; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (acc_d !== 7'd5) begin failures++; $display("FAIL mid_new_acc got %0d exp 5", acc_d); end
        tests++; if (st_d !== 2'd2) begin failures++; $display("FAIL mid_new_state got %0d exp 2", st_d); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_auto_terminate();
        test_backpressure();
        test_overflow();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
